// File: rtl/switch_mcu_regfile.sv
// Architectural register file x0..x(2**ADDR_W-1): two registered read ports, one write port,
// optional same-cycle write-to-read bypass and a saturating committed-write counter.
module switch_mcu_regfile #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter bit BYPASS = 1'b1
) (
  input  logic              in_clk,
  input  logic              in_rst,
  input  logic              in_ren_1,
  input  logic [ADDR_W-1:0] in_raddr_1,
  output logic [DATA_W-1:0] out_rdata_1,
  output logic              out_rvalid_1,
  input  logic              in_ren_2,
  input  logic [ADDR_W-1:0] in_raddr_2,
  output logic [DATA_W-1:0] out_rdata_2,
  output logic              out_rvalid_2,
  input  logic              in_wen,
  input  logic [ADDR_W-1:0] in_waddr,
  input  logic [DATA_W-1:0] in_wdata,
  output logic [15:0]       out_wr_cnt
);

  localparam int NREG = 2 ** ADDR_W;

  logic [DATA_W-1:0] r_regs [NREG];
  logic [DATA_W-1:0] r_rdata_1;
  logic [DATA_W-1:0] r_rdata_2;
  logic              r_rvalid_1;
  logic              r_rvalid_2;
  logic [15:0]       r_wr_cnt;

  logic              w_wr_commit;
  logic [DATA_W-1:0] w_rd_next_1;
  logic [DATA_W-1:0] w_rd_next_2;

  assign w_wr_commit = in_wen && (in_waddr != '0);

  // x0 reads as zero ahead of any bypass match
  always_comb begin
    w_rd_next_1 = r_regs[in_raddr_1];
    if (in_raddr_1 == '0)
      w_rd_next_1 = '0;
    else if (BYPASS && in_wen && (in_waddr == in_raddr_1))
      w_rd_next_1 = in_wdata;
  end

  always_comb begin
    w_rd_next_2 = r_regs[in_raddr_2];
    if (in_raddr_2 == '0)
      w_rd_next_2 = '0;
    else if (BYPASS && in_wen && (in_waddr == in_raddr_2))
      w_rd_next_2 = in_wdata;
  end

  always_ff @(posedge in_clk or negedge in_rst) begin
    if (!in_rst) begin
      for (int i = 0; i < NREG; i++)
        r_regs[i] <= '0;
    end else if (w_wr_commit) begin
      r_regs[in_waddr] <= in_wdata;
    end
  end

  always_ff @(posedge in_clk or negedge in_rst) begin
    if (!in_rst) begin
      r_rdata_1  <= '0;
      r_rdata_2  <= '0;
      r_rvalid_1 <= 1'b0;
      r_rvalid_2 <= 1'b0;
    end else begin
      r_rvalid_1 <= in_ren_1;
      r_rvalid_2 <= in_ren_2;
      if (in_ren_1)
        r_rdata_1 <= w_rd_next_1;
      if (in_ren_2)
        r_rdata_2 <= w_rd_next_2;
    end
  end

  always_ff @(posedge in_clk or negedge in_rst) begin
    if (!in_rst)
      r_wr_cnt <= '0;
    else if (w_wr_commit && (r_wr_cnt != 16'hFFFF))
      r_wr_cnt <= r_wr_cnt + 16'd1;
  end

  assign out_rdata_1  = r_rdata_1;
  assign out_rdata_2  = r_rdata_2;
  assign out_rvalid_1 = r_rvalid_1;
  assign out_rvalid_2 = r_rvalid_2;
  assign out_wr_cnt   = r_wr_cnt;

endmodule

// File: tb/tb_switch_mcu_regfile.sv
// Directed bench for switch_mcu_regfile: one bypassing and one non-bypassing instance
// share the same stimulus; expected values are hand-computed constants.
module tb_switch_mcu_regfile;

  logic        in_clk;
  logic        in_rst;
  logic        in_ren_1;
  logic [4:0]  in_raddr_1;
  logic        in_ren_2;
  logic [4:0]  in_raddr_2;
  logic        in_wen;
  logic [4:0]  in_waddr;
  logic [31:0] in_wdata;

  logic [31:0] rdata_1, rdata_2, nb_rdata_1, nb_rdata_2;
  logic        rvalid_1, rvalid_2, nb_rvalid_1, nb_rvalid_2;
  logic [15:0] wr_cnt, nb_wr_cnt;

  int n_checks = 0;
  int n_errors = 0;

  switch_mcu_regfile #(.DATA_W(32), .ADDR_W(5), .BYPASS(1'b1)) u_dut (
    .in_clk(in_clk), .in_rst(in_rst),
    .in_ren_1(in_ren_1), .in_raddr_1(in_raddr_1),
    .out_rdata_1(rdata_1), .out_rvalid_1(rvalid_1),
    .in_ren_2(in_ren_2), .in_raddr_2(in_raddr_2),
    .out_rdata_2(rdata_2), .out_rvalid_2(rvalid_2),
    .in_wen(in_wen), .in_waddr(in_waddr), .in_wdata(in_wdata),
    .out_wr_cnt(wr_cnt)
  );

  switch_mcu_regfile #(.DATA_W(32), .ADDR_W(5), .BYPASS(1'b0)) u_dut_nb (
    .in_clk(in_clk), .in_rst(in_rst),
    .in_ren_1(in_ren_1), .in_raddr_1(in_raddr_1),
    .out_rdata_1(nb_rdata_1), .out_rvalid_1(nb_rvalid_1),
    .in_ren_2(in_ren_2), .in_raddr_2(in_raddr_2),
    .out_rdata_2(nb_rdata_2), .out_rvalid_2(nb_rvalid_2),
    .in_wen(in_wen), .in_waddr(in_waddr), .in_wdata(in_wdata),
    .out_wr_cnt(nb_wr_cnt)
  );

  initial in_clk = 1'b0;
  always #5 in_clk = ~in_clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge in_clk);
    #1;
  endtask

  task automatic idle();
    in_ren_1 = 1'b0; in_raddr_1 = '0;
    in_ren_2 = 1'b0; in_raddr_2 = '0;
    in_wen   = 1'b0; in_waddr   = '0; in_wdata = '0;
  endtask

  initial begin
    idle();
    in_rst = 1'b0;
    tick(); tick();
    chk("rst_rdata_1", rdata_1, 32'h0);
    chk("rst_rvalid_1", {31'b0, rvalid_1}, 32'h0);
    chk("rst_rdata_2", rdata_2, 32'h0);
    chk("rst_rvalid_2", {31'b0, rvalid_2}, 32'h0);
    chk("rst_wr_cnt", {16'b0, wr_cnt}, 32'h0);
    in_rst = 1'b1;
    tick();

    // every index reads zero after reset, on both ports
    for (int i = 0; i < 32; i++) begin
      in_ren_1 = 1'b1; in_raddr_1 = 5'(i);
      in_ren_2 = 1'b1; in_raddr_2 = 5'(31 - i);
      tick();
      chk("zero_rdata_1", rdata_1, 32'h0);
      chk("zero_rvalid_1", {31'b0, rvalid_1}, 32'h1);
      chk("zero_rdata_2", rdata_2, 32'h0);
      chk("zero_rvalid_2", {31'b0, rvalid_2}, 32'h1);
    end
    idle();
    tick();
    chk("zero_rvalid_1_drop", {31'b0, rvalid_1}, 32'h0);
    chk("zero_rvalid_2_drop", {31'b0, rvalid_2}, 32'h0);

    // write x5, read it back on port 1, valid pulses once and data holds
    in_wen = 1'b1; in_waddr = 5'd5; in_wdata = 32'hDEADBEEF;
    tick();
    idle();
    in_ren_1 = 1'b1; in_raddr_1 = 5'd5;
    tick();
    chk("x5_rdata_1", rdata_1, 32'hDEADBEEF);
    chk("x5_rvalid_1", {31'b0, rvalid_1}, 32'h1);
    chk("x5_rvalid_2_idle", {31'b0, rvalid_2}, 32'h0);
    idle();
    tick();
    chk("x5_rvalid_1_drop", {31'b0, rvalid_1}, 32'h0);
    chk("x5_rdata_1_hold", rdata_1, 32'hDEADBEEF);
    chk("x5_wr_cnt", {16'b0, wr_cnt}, 32'h1);

    // writes to x0 are discarded and not counted
    in_wen = 1'b1; in_waddr = 5'd0; in_wdata = 32'h12345678;
    tick();
    idle();
    in_ren_2 = 1'b1; in_raddr_2 = 5'd0;
    tick();
    chk("x0_rdata_2", rdata_2, 32'h0);
    chk("x0_rvalid_2", {31'b0, rvalid_2}, 32'h1);
    chk("x0_wr_cnt", {16'b0, wr_cnt}, 32'h1);

    // x0 read while x0 is being written still returns zero even with bypass
    in_wen = 1'b1; in_waddr = 5'd0; in_wdata = 32'hCAFEF00D;
    in_ren_1 = 1'b1; in_raddr_1 = 5'd0;
    tick();
    chk("x0_bypass_rdata_1", rdata_1, 32'h0);
    idle();

    // same-cycle write/read of x7 on both ports
    in_wen = 1'b1; in_waddr = 5'd7; in_wdata = 32'h1;
    tick();
    in_wdata = 32'hA5A5A5A5;
    in_ren_1 = 1'b1; in_raddr_1 = 5'd7;
    in_ren_2 = 1'b1; in_raddr_2 = 5'd7;
    tick();
    chk("byp_rdata_1", rdata_1, 32'hA5A5A5A5);
    chk("byp_rdata_2", rdata_2, 32'hA5A5A5A5);
    chk("nobyp_rdata_1", nb_rdata_1, 32'h1);
    chk("nobyp_rdata_2", nb_rdata_2, 32'h1);
    idle();
    in_ren_1 = 1'b1; in_raddr_1 = 5'd7;
    in_ren_2 = 1'b1; in_raddr_2 = 5'd7;
    tick();
    chk("x7_after_rdata_1", rdata_1, 32'hA5A5A5A5);
    chk("x7_after_nb_rdata_2", nb_rdata_2, 32'hA5A5A5A5);
    chk("x7_wr_cnt", {16'b0, wr_cnt}, 32'h3);

    // bypass applies only to the matching index
    in_wen = 1'b1; in_waddr = 5'd9; in_wdata = 32'h99;
    in_ren_1 = 1'b1; in_raddr_1 = 5'd5;
    in_ren_2 = 1'b1; in_raddr_2 = 5'd9;
    tick();
    chk("mix_rdata_1", rdata_1, 32'hDEADBEEF);
    chk("mix_rdata_2", rdata_2, 32'h99);
    chk("mix_nb_rdata_1", nb_rdata_1, 32'hDEADBEEF);
    chk("mix_nb_rdata_2", nb_rdata_2, 32'h0);
    chk("mix_wr_cnt", {16'b0, wr_cnt}, 32'h4);
    chk("mix_nb_wr_cnt", {16'b0, nb_wr_cnt}, 32'h4);

    // asynchronous reset with a read and a write of x3 pending
    in_wen = 1'b1; in_waddr = 5'd3; in_wdata = 32'hFF;
    in_ren_1 = 1'b1; in_raddr_1 = 5'd3;
    in_ren_2 = 1'b0;
    #3;
    in_rst = 1'b0;
    #1;
    chk("arst_rdata_1", rdata_1, 32'h0);
    chk("arst_rdata_2", rdata_2, 32'h0);
    chk("arst_rvalid_1", {31'b0, rvalid_1}, 32'h0);
    chk("arst_wr_cnt", {16'b0, wr_cnt}, 32'h0);
    tick();
    chk("arst_hold_rvalid_1", {31'b0, rvalid_1}, 32'h0);
    chk("arst_hold_wr_cnt", {16'b0, wr_cnt}, 32'h0);
    in_rst = 1'b1;
    idle();
    in_ren_1 = 1'b1; in_raddr_1 = 5'd3;
    in_ren_2 = 1'b1; in_raddr_2 = 5'd5;
    tick();
    chk("post_rst_x3", rdata_1, 32'h0);
    chk("post_rst_x5", rdata_2, 32'h0);
    chk("post_rst_rvalid_1", {31'b0, rvalid_1}, 32'h1);
    idle();

    // drive the write counter to saturation
    in_wen = 1'b1; in_waddr = 5'd1;
    for (int i = 0; i < 65534; i++) begin
      in_wdata = 32'(i);
      tick();
    end
    chk("cnt_fffe", {16'b0, wr_cnt}, 32'h0000FFFE);
    in_wdata = 32'h1111; tick();
    chk("cnt_sat_1", {16'b0, wr_cnt}, 32'h0000FFFF);
    in_wdata = 32'h2222; tick();
    chk("cnt_sat_2", {16'b0, wr_cnt}, 32'h0000FFFF);
    in_wdata = 32'h3333; tick();
    chk("cnt_sat_3", {16'b0, wr_cnt}, 32'h0000FFFF);
    chk("cnt_sat_nb", {16'b0, nb_wr_cnt}, 32'h0000FFFF);
    idle();
    in_ren_1 = 1'b1; in_raddr_1 = 5'd1;
    tick();
    chk("sat_last_x1", rdata_1, 32'h3333);
    idle();
    tick();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/switch_mcu_regfile.md
Name: switch_mcu_regfile

Overview:
- Architectural register file (x0..x31) for the switch MCU core.
- Responder for the ALU op units' register read/write request ports.
- Two registered read ports and one write port.
- ALU units drive ren/raddr and wen/waddr/wdata as registered outputs. This block returns read data one clock after the request is sampled, so it is stable before the requester's data-use cycle.

Parameters:
- DATA_W, 32, register data width.
- ADDR_W, 5, register index width; register count is 2**ADDR_W.
- BYPASS, 1, 1 = a read of an index being written in the same cycle returns the new data; 0 = it returns the old data.

Ports:
- in_clk  input  1  core clock, rising edge.
- in_rst  input  1  asynchronous, active-low reset.
- in_ren_1  input  1  read port 1 request.
- in_raddr_1  input  ADDR_W  read port 1 index.
- out_rdata_1  output  DATA_W  read port 1 data, registered.
- out_rvalid_1  output  1  read port 1 data-valid pulse.
- in_ren_2  input  1  read port 2 request.
- in_raddr_2  input  ADDR_W  read port 2 index.
- out_rdata_2  output  DATA_W  read port 2 data, registered.
- out_rvalid_2  output  1  read port 2 data-valid pulse.
- in_wen  input  1  write request.
- in_waddr  input  ADDR_W  write index.
- in_wdata  input  DATA_W  write data.
- out_wr_cnt  output  16  count of committed writes (debug), saturating.

Behaviour:
- One clock; reset is asynchronous and active-low on in_rst (low = reset).
- Reset (in_rst low), asynchronous:
  - all registers = 0.
  - out_rdata_1/2 = 0, out_rvalid_1/2 = 0, out_wr_cnt = 0.
  - takes effect immediately, mid-access included; any request pending at that edge is dropped.
- Write: at a rising edge with in_wen=1 and in_waddr!=0, reg[in_waddr] <= in_wdata.
  - Writes with in_waddr=0 are discarded; x0 stays 0.
  - Writes are never stalled and have no acknowledge.
- Write counter: out_wr_cnt increments by 1 on each committed write (in_wen=1, in_waddr!=0). It saturates at 16'hFFFF and never wraps.
- Read port k (k=1,2), rising edge:
  - out_rvalid_k <= in_ren_k.
  - If in_ren_k=1, out_rdata_k takes the first matching case:
    - in_raddr_k==0 -> 0.
    - BYPASS=1, in_wen=1 and in_waddr==in_raddr_k -> in_wdata.
    - otherwise -> reg[in_raddr_k] (pre-edge value).
  - If in_ren_k=0: out_rdata_k holds its last value; out_rvalid_k = 0.
- Latency: request sampled at edge N -> data and valid visible after edge N. The requester samples the data at edge N+1 or later.
- Both ports are independent. The same index may be read on both ports in the same cycle, with identical results.
- Back-to-back requests on every cycle are supported with throughput 1 per port per cycle.
- No X propagation: all outputs are driven from flops; indices are full-range, so no out-of-range case exists.
- Storage: flop array, not inferred RAM, because of the asynchronous reset-to-zero requirement.

Test Plan:
- Reset, then read all 32 indices on both ports -> every out_rdata = 0; out_rvalid pulses 1 cycle per request.
- Write x5=32'hDEADBEEF; next cycle ren_1 raddr_1=5 -> after the following edge out_rdata_1=32'hDEADBEEF, out_rvalid_1=1, then out_rvalid_1=0 with the data held.
- Write x0=32'h12345678, then read x0 on port 2 -> out_rdata_2=0; out_wr_cnt unchanged.
- Same-cycle write x7=32'hA5A5A5A5 and read x7 on both ports (x7 previously 32'h1) -> BYPASS=1: both ports return 32'hA5A5A5A5; BYPASS=0: both return 32'h1.
- Drive in_rst low while ren_1=1 and wen=1 (x3=32'hFF) are pending at an edge -> all outputs 0 immediately; after release, reading x3 returns 0.
- Preload out_wr_cnt to 16'hFFFE via 65534 writes, then issue 3 more writes -> count reads 16'hFFFF and stays there.
